axid_rresp_match: RTL and testbench

//  Read-response stage downstream of the AXID store. Matches each R beat's RID against the per-FIFO AXID

---
 rtl/axid_rresp_match_pkg.sv | 16 +
 rtl/axid_match_enc.sv | 31 +++
 rtl/axid_rresp_match.sv | 181 ++++++++++++++++++
 tb/tb_axid_rresp_match.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axid_rresp_match_pkg.sv
// Shared definitions for the AXID read-response match stage: pop FSM encodings and width helpers.
// No logic of its own; imported by the matcher and its encoder.
package axid_rresp_match_pkg;

  localparam int BEAT_CNT_W = 8;

  localparam logic [1:0] POP_IDLE   = 2'd0;
  localparam logic [1:0] POP_POP    = 2'd1;
  localparam logic [1:0] POP_SETTLE = 2'd2;

  // Index width that stays at least one bit when there is a single FIFO.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axid_match_enc.sv
// Combinational AXID matcher: compares an ID against every valid FIFO's AXID, reports any hit
// and the lowest matching index. Zero latency, no flow control; shared with the B-channel matcher.
module axid_match_enc #(
  parameter int N     = 16,
  parameter int ID_W  = 4,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]      valid,
  input  logic [N*ID_W-1:0] ids,
  input  logic [ID_W-1:0]   id,
  output logic              hit_any,
  output logic [IDX_W-1:0]  idx
);

  logic [N-1:0] hit;

  for (genvar k = 0; k < N; k++) begin : g_hit
    assign hit[k] = valid[k] && (ids[k*ID_W +: ID_W] == id);
  end

  assign hit_any = |hit;

  // Multiple hits are illegal upstream; scanning downward makes the lowest index win anyway.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/axid_rresp_match.sv
// Tags R beats with the head descriptor ID of the AXID FIFO whose AXID matches RID; pops on RLAST.
// Two register stages (R handshake N -> resp_valid N+2); a last beat blocks S1 until pop + settle finish.
module axid_rresp_match
  import axid_rresp_match_pkg::*;
#(
  parameter int  MAX_DESC           = 16,
  parameter int  M_AXI_USR_ID_WIDTH = 4,
  parameter int  DATA_WIDTH         = 128,
  localparam int DESC_W             = idx_width(MAX_DESC)
) (
  input  logic                               axi_aclk,
  input  logic                               axi_aresetn,
  input  logic [M_AXI_USR_ID_WIDTH-1:0]      m_axi_usr_rid,
  input  logic [DATA_WIDTH-1:0]              m_axi_usr_rdata,
  input  logic [1:0]                         m_axi_usr_rresp,
  input  logic                               m_axi_usr_rlast,
  input  logic                               m_axi_usr_rvalid,
  output logic                               m_axi_usr_rready,
  input  logic [MAX_DESC-1:0]                fifo_id_reg_valid_ff,
  input  logic [MAX_DESC*M_AXI_USR_ID_WIDTH-1:0] fifo_id_regs,
  input  logic [MAX_DESC*DESC_W-1:0]         axid_response_ids,
  input  logic                               desc_allocation_in_progress,
  output logic [MAX_DESC-1:0]                axid_read_en,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [DESC_W-1:0]                  resp_desc_id,
  output logic [DATA_WIDTH-1:0]              resp_data,
  output logic [1:0]                         resp_resp,
  output logic                               resp_last,
  output logic [BEAT_CNT_W-1:0]              resp_beat_cnt,
  output logic                               err_unmatched,
  output logic                               err_unmatched_sticky,
  input  logic                               err_clear
);

  logic                          s1_valid_q, s1_valid_d;
  logic [M_AXI_USR_ID_WIDTH-1:0] s1_rid_q, s1_rid_d;
  logic [DATA_WIDTH-1:0]         s1_data_q, s1_data_d;
  logic [1:0]                    s1_resp_q, s1_resp_d;
  logic                          s1_last_q, s1_last_d;

  logic                          s2_valid_q, s2_valid_d;
  logic [DESC_W-1:0]             s2_desc_q, s2_desc_d;
  logic [DATA_WIDTH-1:0]         s2_data_q, s2_data_d;
  logic [1:0]                    s2_resp_q, s2_resp_d;
  logic                          s2_last_q, s2_last_d;
  logic [DESC_W-1:0]             s2_idx_q, s2_idx_d;
  logic [BEAT_CNT_W-1:0]         s2_cnt_q, s2_cnt_d;

  logic [1:0]                    pop_state_q, pop_state_d;
  logic                          err_sticky_q, err_sticky_d;
  logic [BEAT_CNT_W-1:0]         beat_cnt_q [MAX_DESC];
  logic [BEAT_CNT_W-1:0]         beat_cnt_d [MAX_DESC];

  logic                          match_any;
  logic [DESC_W-1:0]             match_idx;
  logic                          s1_adv;
  logic                          r_hs;
  logic                          s2_hs;

  axid_match_enc #(
    .N     (MAX_DESC),
    .ID_W  (M_AXI_USR_ID_WIDTH),
    .IDX_W (DESC_W)
  ) u_match_enc (
    .valid   (fifo_id_reg_valid_ff),
    .ids     (fifo_id_regs),
    .id      (s1_rid_q),
    .hit_any (match_any),
    .idx     (match_idx)
  );

  // Holding S1 while S2 carries a last beat keeps the next match from seeing a stale FIFO head.
  assign s1_adv = s1_valid_q && (pop_state_q == POP_IDLE) && !desc_allocation_in_progress
                  && (!s2_valid_q || (resp_ready && !s2_last_q));
  assign m_axi_usr_rready = axi_aresetn && (!s1_valid_q || s1_adv);
  assign r_hs             = m_axi_usr_rvalid && m_axi_usr_rready;
  assign s2_hs            = s2_valid_q && resp_ready;
  assign err_unmatched    = s1_adv && !match_any;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_rid_d     = s1_rid_q;
    s1_data_d    = s1_data_q;
    s1_resp_d    = s1_resp_q;
    s1_last_d    = s1_last_q;
    s2_valid_d   = s2_valid_q;
    s2_desc_d    = s2_desc_q;
    s2_data_d    = s2_data_q;
    s2_resp_d    = s2_resp_q;
    s2_last_d    = s2_last_q;
    s2_idx_d     = s2_idx_q;
    s2_cnt_d     = s2_cnt_q;
    pop_state_d  = pop_state_q;
    err_sticky_d = err_sticky_q;
    beat_cnt_d   = beat_cnt_q;

    if (r_hs) begin
      s1_valid_d = 1'b1;
      s1_rid_d   = m_axi_usr_rid;
      s1_data_d  = m_axi_usr_rdata;
      s1_resp_d  = m_axi_usr_rresp;
      s1_last_d  = m_axi_usr_rlast;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_hs) s2_valid_d = 1'b0;

    if (s1_adv && match_any) begin
      s2_valid_d            = 1'b1;
      s2_desc_d             = axid_response_ids[match_idx*DESC_W +: DESC_W];
      s2_data_d             = s1_data_q;
      s2_resp_d             = s1_resp_q;
      s2_last_d             = s1_last_q;
      s2_idx_d              = match_idx;
      s2_cnt_d              = beat_cnt_q[match_idx];
      beat_cnt_d[match_idx] = s1_last_q ? '0 : beat_cnt_q[match_idx] + 1'b1;
    end

    if (err_clear)     err_sticky_d = 1'b0;
    if (err_unmatched) err_sticky_d = 1'b1;

    case (pop_state_q)
      POP_IDLE:   if (s2_hs && s2_last_q) pop_state_d = POP_POP;
      POP_POP:    pop_state_d = POP_SETTLE;
      default:    pop_state_d = POP_IDLE;
    endcase
  end

  // s2_idx_q cannot change while popping: S1 is frozen outside IDLE.
  always_comb begin
    axid_read_en = '0;
    if (pop_state_q == POP_POP) axid_read_en[s2_idx_q] = 1'b1;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      s1_valid_q   <= 1'b0;
      s1_rid_q     <= '0;
      s1_data_q    <= '0;
      s1_resp_q    <= '0;
      s1_last_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_desc_q    <= '0;
      s2_data_q    <= '0;
      s2_resp_q    <= '0;
      s2_last_q    <= 1'b0;
      s2_idx_q     <= '0;
      s2_cnt_q     <= '0;
      pop_state_q  <= POP_IDLE;
      err_sticky_q <= 1'b0;
      for (int k = 0; k < MAX_DESC; k++) beat_cnt_q[k] <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_rid_q     <= s1_rid_d;
      s1_data_q    <= s1_data_d;
      s1_resp_q    <= s1_resp_d;
      s1_last_q    <= s1_last_d;
      s2_valid_q   <= s2_valid_d;
      s2_desc_q    <= s2_desc_d;
      s2_data_q    <= s2_data_d;
      s2_resp_q    <= s2_resp_d;
      s2_last_q    <= s2_last_d;
      s2_idx_q     <= s2_idx_d;
      s2_cnt_q     <= s2_cnt_d;
      pop_state_q  <= pop_state_d;
      err_sticky_q <= err_sticky_d;
      for (int k = 0; k < MAX_DESC; k++) beat_cnt_q[k] <= beat_cnt_d[k];
    end
  end

  assign resp_valid           = s2_valid_q;
  assign resp_desc_id         = s2_desc_q;
  assign resp_data            = s2_data_q;
  assign resp_resp            = s2_resp_q;
  assign resp_last            = s2_last_q;
  assign resp_beat_cnt        = s2_cnt_q;
  assign err_unmatched_sticky = err_sticky_q;

endmodule

// File: tb/tb_axid_rresp_match.sv
// Directed bench for axid_rresp_match: a small AXID FIFO model feeds the match tables, monitors
// log every accepted beat and pop, and expected values are hand-derived per scenario.
module tb_axid_rresp_match;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [15:0]  fvalid;
  logic [63:0]  fids;
  logic [63:0]  fdesc;
  logic         alloc;
  logic [15:0]  read_en;
  logic         resp_valid;
  logic         resp_ready;
  logic [3:0]   resp_desc_id;
  logic [127:0] resp_data;
  logic [1:0]   resp_resp;
  logic         resp_last;
  logic [7:0]   resp_beat_cnt;
  logic         err_pulse;
  logic         err_sticky;
  logic         err_clear;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axid_rresp_match #(.MAX_DESC(16), .M_AXI_USR_ID_WIDTH(4), .DATA_WIDTH(128)) dut (
    .axi_aclk                    (clk),
    .axi_aresetn                 (rst_n),
    .m_axi_usr_rid               (rid),
    .m_axi_usr_rdata             (rdata),
    .m_axi_usr_rresp             (rresp),
    .m_axi_usr_rlast             (rlast),
    .m_axi_usr_rvalid            (rvalid),
    .m_axi_usr_rready            (rready),
    .fifo_id_reg_valid_ff        (fvalid),
    .fifo_id_regs                (fids),
    .axid_response_ids           (fdesc),
    .desc_allocation_in_progress (alloc),
    .axid_read_en                (read_en),
    .resp_valid                  (resp_valid),
    .resp_ready                  (resp_ready),
    .resp_desc_id                (resp_desc_id),
    .resp_data                   (resp_data),
    .resp_resp                   (resp_resp),
    .resp_last                   (resp_last),
    .resp_beat_cnt               (resp_beat_cnt),
    .err_unmatched               (err_pulse),
    .err_unmatched_sticky        (err_sticky),
    .err_clear                   (err_clear)
  );

  // AXID FIFO model: contents written by the stimulus, head pointer advanced by pops.
  logic [3:0] q_id   [16];
  logic [3:0] q_desc [16][4];
  int         q_n    [16];
  int         q_base [16];
  int         hd     [16];

  initial for (int k = 0; k < 16; k++) hd[k] = 0;

  always @(posedge clk)
    for (int k = 0; k < 16; k++) if (read_en[k]) hd[k] <= hd[k] + 1;

  always_comb begin
    fvalid = '0;
    fids   = '0;
    fdesc  = '0;
    for (int k = 0; k < 16; k++) begin
      int pos;
      pos = hd[k] - q_base[k];
      fids[k*4 +: 4] = q_id[k];
      if (pos >= 0 && pos < q_n[k]) begin
        fvalid[k]       = 1'b1;
        fdesc[k*4 +: 4] = q_desc[k][pos[1:0]];
      end
    end
  end

  // Monitors: accepted beats, pop pulses, error pulses, longest rready stall seen by the source.
  logic [3:0]   rec_desc [$];
  logic [7:0]   rec_cnt  [$];
  logic         rec_last [$];
  logic [1:0]   rec_resp [$];
  logic [127:0] rec_data [$];
  logic [15:0]  pop_log  [$];
  int           err_cnt  = 0;
  int           cur_gap  = 0;
  int           max_gap  = 0;
  logic         gap_clr  = 1'b0;

  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      rec_desc.push_back(resp_desc_id);
      rec_cnt.push_back(resp_beat_cnt);
      rec_last.push_back(resp_last);
      rec_resp.push_back(resp_resp);
      rec_data.push_back(resp_data);
    end
    if (read_en != 16'h0) pop_log.push_back(read_en);
    if (err_pulse) err_cnt++;
    if (gap_clr) begin
      cur_gap = 0;
      max_gap = 0;
    end else if (rvalid && !rready) begin
      cur_gap++;
      if (cur_gap > max_gap) max_gap = cur_gap;
    end else begin
      cur_gap = 0;
    end
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < 16; k++) begin
      q_n[k]    = 0;
      q_base[k] = hd[k];
      q_id[k]   = 4'h0;
      for (int j = 0; j < 4; j++) q_desc[k][j] = 4'h0;
    end
  endtask

  task automatic set_fifo(input int k, input logic [3:0] id, input int n,
                          input logic [3:0] d0, input logic [3:0] d1);
    q_id[k]      = id;
    q_desc[k][0] = d0;
    q_desc[k][1] = d1;
    q_base[k]    = hd[k];
    q_n[k]       = n;
  endtask

  function automatic logic [127:0] pat(input logic [3:0] id, input int beat);
    logic [127:0] p;
    p = {32'hA5A5_0000, 28'h0, id, 32'h0, 32'(beat)};
    return p;
  endfunction

  task automatic send_beat(input logic [3:0] id, input int beat, input logic last);
    bit acc;
    int t;
    acc    = 1'b0;
    t      = 0;
    rid    = id;
    rdata  = pat(id, beat);
    rresp  = id[1:0];
    rlast  = last;
    rvalid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      if (rready) acc = 1'b1;
      t++;
    end
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    if (!acc) check($sformatf("rready_timeout_id%0h_b%0d", id, beat), acc, 1'b1);
  endtask

  task automatic check_rec(input string tn, input int i, input logic [3:0] d,
                           input logic [7:0] c, input logic l, input logic [127:0] dat);
    if (i >= rec_desc.size()) begin
      check($sformatf("%s_missing%0d", tn, i), rec_desc.size(), i + 1);
    end else begin
      check($sformatf("%s_desc%0d", tn, i), rec_desc[i], d);
      check($sformatf("%s_cnt%0d", tn, i), rec_cnt[i], c);
      check($sformatf("%s_last%0d", tn, i), rec_last[i], l);
      check($sformatf("%s_data%0d", tn, i), rec_data[i], dat);
    end
  endtask

  initial begin
    int rb, pb, eb;
    rst_n      = 1'b0;
    rid        = '0;
    rdata      = '0;
    rresp      = '0;
    rlast      = 1'b0;
    rvalid     = 1'b0;
    alloc      = 1'b0;
    resp_ready = 1'b1;
    err_clear  = 1'b0;
    clear_fifos();

    // Reset state
    cyc(3);
    @(negedge clk);
    check("rst_rready", rready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_read_en", read_en, 16'h0);
    check("rst_err", {err_pulse, err_sticky}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1);

    // 1: single burst, first beat held back by allocation in progress
    set_fifo(0, 4'h3, 1, 4'h5, 4'h0);
    rb = rec_desc.size(); pb = pop_log.size();
    alloc = 1'b1;
    send_beat(4'h3, 0, 1'b0);
    cyc(3);
    @(negedge clk);
    check("t1_alloc_no_valid", resp_valid, 1'b0);
    check("t1_alloc_rready", rready, 1'b0);
    @(posedge clk); #1;
    alloc = 1'b0;
    for (int b = 1; b < 4; b++) send_beat(4'h3, b, b == 3);
    cyc(12);
    check("t1_beats", rec_desc.size() - rb, 4);
    for (int b = 0; b < 4; b++) check_rec("t1", rb + b, 4'h5, 8'(b), b == 3, pat(4'h3, b));
    check("t1_resp", rec_resp[rb], 2'd3);
    check("t1_pops", pop_log.size() - pb, 1);
    check("t1_pop_en", pop_log[pb], 16'h0001);

    // 2: interleaved IDs
    clear_fifos();
    set_fifo(1, 4'h2, 1, 4'h7, 4'h0);
    set_fifo(4, 4'h9, 1, 4'h1, 4'h0);
    rb = rec_desc.size(); pb = pop_log.size();
    send_beat(4'h2, 0, 1'b0);
    send_beat(4'h9, 0, 1'b0);
    send_beat(4'h2, 1, 1'b1);
    send_beat(4'h9, 1, 1'b1);
    cyc(15);
    check("t2_beats", rec_desc.size() - rb, 4);
    check_rec("t2", rb + 0, 4'h7, 8'd0, 1'b0, pat(4'h2, 0));
    check_rec("t2", rb + 1, 4'h1, 8'd0, 1'b0, pat(4'h9, 0));
    check_rec("t2", rb + 2, 4'h7, 8'd1, 1'b1, pat(4'h2, 1));
    check_rec("t2", rb + 3, 4'h1, 8'd1, 1'b1, pat(4'h9, 1));
    check("t2_pops", pop_log.size() - pb, 2);
    check("t2_pop0", pop_log[pb], 16'h0002);
    check("t2_pop1", pop_log[pb + 1], 16'h0010);

    // 3: same ID twice, head descriptor must advance across the pop
    clear_fifos();
    set_fifo(0, 4'h0, 2, 4'h2, 4'h6);
    rb = rec_desc.size(); pb = pop_log.size();
    gap_clr = 1'b1; @(negedge clk); gap_clr = 1'b0;
    @(posedge clk); #1;
    send_beat(4'h0, 0, 1'b0);
    send_beat(4'h0, 1, 1'b1);
    send_beat(4'h0, 2, 1'b0);
    send_beat(4'h0, 3, 1'b1);
    cyc(12);
    check("t3_beats", rec_desc.size() - rb, 4);
    check_rec("t3", rb + 0, 4'h2, 8'd0, 1'b0, pat(4'h0, 0));
    check_rec("t3", rb + 1, 4'h2, 8'd1, 1'b1, pat(4'h0, 1));
    check_rec("t3", rb + 2, 4'h6, 8'd0, 1'b0, pat(4'h0, 2));
    check_rec("t3", rb + 3, 4'h6, 8'd1, 1'b1, pat(4'h0, 3));
    check("t3_gap_le3", max_gap <= 3, 1'b1);
    check("t3_pops", pop_log.size() - pb, 2);

    // 4: unmatched ID
    clear_fifos();
    rb = rec_desc.size(); eb = err_cnt;
    send_beat(4'hE, 0, 1'b1);
    cyc(5);
    check("t4_no_beat", rec_desc.size() - rb, 0);
    check("t4_err_pulses", err_cnt - eb, 1);
    check("t4_sticky", err_sticky, 1'b1);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    check("t4_sticky_clr", err_sticky, 1'b0);

    // 5: backpressure mid-burst
    clear_fifos();
    set_fifo(2, 4'h5, 1, 4'h3, 4'h0);
    rb = rec_desc.size(); pb = pop_log.size();
    fork
      for (int b = 0; b < 4; b++) send_beat(4'h5, b, b == 3);
      begin
        int t;
        logic [143:0] snap;
        bit changed;
        t = 0;
        changed = 1'b0;
        while (rec_desc.size() < rb + 1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        check("t5_first_beat", rec_desc.size() >= rb + 1, 1'b1);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        snap = {resp_valid, resp_desc_id, resp_data, resp_beat_cnt, resp_last, resp_resp};
        repeat (4) begin
          @(negedge clk);
          if ({resp_valid, resp_desc_id, resp_data, resp_beat_cnt, resp_last, resp_resp} !== snap)
            changed = 1'b1;
        end
        check("t5_stable", changed, 1'b0);
        check("t5_held_valid", resp_valid, 1'b1);
        check("t5_rready_low", rready, 1'b0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
      end
    join
    cyc(12);
    check("t5_beats", rec_desc.size() - rb, 4);
    for (int b = 0; b < 4; b++) check_rec("t5", rb + b, 4'h3, 8'(b), b == 3, pat(4'h5, b));
    check("t5_pop", pop_log[pb], 16'h0004);

    // 6: reset mid-burst, counter restarts
    clear_fifos();
    set_fifo(3, 4'h7, 1, 4'h4, 4'h0);
    send_beat(4'h7, 0, 1'b0);
    send_beat(4'h7, 1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_valid", resp_valid, 1'b0);
    check("t6_rst_fields", {resp_desc_id, resp_beat_cnt, resp_last, resp_resp}, 15'h0);
    check("t6_rst_data", resp_data, 128'h0);
    check("t6_rst_rready", rready, 1'b0);
    check("t6_rst_read_en", read_en, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1);
    rb = rec_desc.size(); pb = pop_log.size();
    for (int b = 0; b < 4; b++) send_beat(4'h7, b, b == 3);
    cyc(12);
    check("t6_beats", rec_desc.size() - rb, 4);
    for (int b = 0; b < 4; b++) check_rec("t6", rb + b, 4'h4, 8'(b), b == 3, pat(4'h7, b));
    check("t6_pops", pop_log.size() - pb, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
